// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter for fetch and load/store; optional MEM_IO_STALL_EN holds IO-region stores while the UART buffer is full
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n, cnt_inc;
   logic [1:0]  cnt_m1;
   logic [1:0]  last_q, last_n;
   logic [31:0] addr_q, addr_n;
   logic [31:0] wdata_q, wdata_n;
   logic [31:0] rd_buf, buf_n, cap_buf;
   logic        last_grant_ls, lg_n;
   logic [31:0] mem_a_q, mem_a_n;
   logic [7:0]  dout_q, dout_n;
   logic        wr_q, wr_n;
   logic        if_done_q, if_done_n, ls_done_q, ls_done_n;
   logic [31:0] if_data_q, if_data_n, ls_rdata_q, ls_rdata_n;
   logic        sample_ok, take_if, take_ls, grant_ls, grant_if;
   logic [1:0]  ls_last;
   logic        io_stall;

`ifdef MEM_IO_STALL_EN
   assign io_stall = (state == LS_WR) && (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
   logic unused_io;
   assign io_stall  = 1'b0;
   assign unused_io = io_buffer_full;
`endif

   // Requests are not sampled in the turnaround cycle, and a flush blocks new fetches.
   assign sample_ok = (state == IDLE) && !if_done_q && !ls_done_q;
   assign take_if   = sample_ok && if_req && !clr;
   assign take_ls   = sample_ok && ls_req;
   assign grant_ls  = take_ls && (!take_if || !last_grant_ls);
   assign grant_if  = take_if && !grant_ls;
   assign ls_last   = (ls_size == 2'd0) ? 2'd0 : (ls_size == 2'd1) ? 2'd1 : 2'd3;

   assign cnt_inc = cnt + 3'd1;
   assign cnt_m1  = cnt[1:0] - 2'd1;

   // Merge the byte arriving this cycle (address issued last cycle) into the read buffer.
   always_comb begin
      cap_buf = rd_buf;
      cap_buf[{cnt_m1, 3'b000} +: 8] = mem_din;
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      last_n     = last_q;
      addr_n     = addr_q;
      wdata_n    = wdata_q;
      buf_n      = rd_buf;
      lg_n       = last_grant_ls;
      mem_a_n    = mem_a_q;
      dout_n     = dout_q;
      wr_n       = wr_q;
      if_done_n  = 1'b0;
      ls_done_n  = 1'b0;
      if_data_n  = if_data_q;
      ls_rdata_n = ls_rdata_q;
      case (state)
         IDLE: begin
            mem_a_n = 32'd0;
            dout_n  = 8'd0;
            wr_n    = 1'b0;
            if (grant_ls) begin
               addr_n  = ls_addr;
               last_n  = ls_last;
               wdata_n = ls_wdata;
               cnt_n   = 3'd0;
               buf_n   = 32'd0;
               lg_n    = 1'b1;
               mem_a_n = ls_addr;
               if (ls_wr) begin
                  state_n = LS_WR;
                  wr_n    = 1'b1;
                  dout_n  = ls_wdata[7:0];
               end else begin
                  state_n = LS_RD;
               end
            end else if (grant_if) begin
               addr_n  = if_addr;
               last_n  = 2'd3;
               cnt_n   = 3'd0;
               buf_n   = 32'd0;
               lg_n    = 1'b0;
               mem_a_n = if_addr;
               state_n = IF_RD;
            end
         end
         IF_RD, LS_RD: begin
            if (clr) begin
               state_n = IDLE;
               cnt_n   = 3'd0;
               mem_a_n = 32'd0;
            end else begin
               if (cnt != 3'd0) buf_n = cap_buf;
               if (cnt == ({1'b0, last_q} + 3'd1)) begin
                  state_n = IDLE;
                  cnt_n   = 3'd0;
                  mem_a_n = 32'd0;
                  if (state == IF_RD) begin
                     if_done_n = 1'b1;
                     if_data_n = cap_buf;
                  end else begin
                     ls_done_n  = 1'b1;
                     ls_rdata_n = cap_buf;
                  end
               end else begin
                  cnt_n   = cnt_inc;
                  mem_a_n = (cnt_inc <= {1'b0, last_q}) ? addr_q + {29'd0, cnt_inc} : 32'd0;
               end
            end
         end
         LS_WR: begin
            if (!io_stall) begin
               if (cnt == {1'b0, last_q}) begin
                  state_n   = IDLE;
                  cnt_n     = 3'd0;
                  mem_a_n   = 32'd0;
                  dout_n    = 8'd0;
                  wr_n      = 1'b0;
                  ls_done_n = 1'b1;
               end else begin
                  cnt_n   = cnt_inc;
                  mem_a_n = addr_q + {29'd0, cnt_inc};
                  dout_n  = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                  wr_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 3'd0;
         last_q        <= 2'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         rd_buf        <= 32'd0;
         last_grant_ls <= 1'b0;
         mem_a_q       <= 32'd0;
         dout_q        <= 8'd0;
         wr_q          <= 1'b0;
         if_done_q     <= 1'b0;
         ls_done_q     <= 1'b0;
         if_data_q     <= 32'd0;
         ls_rdata_q    <= 32'd0;
      end else if (rdy) begin
         state         <= state_n;
         cnt           <= cnt_n;
         last_q        <= last_n;
         addr_q        <= addr_n;
         wdata_q       <= wdata_n;
         rd_buf        <= buf_n;
         last_grant_ls <= lg_n;
         mem_a_q       <= mem_a_n;
         dout_q        <= dout_n;
         wr_q          <= wr_n;
         if_done_q     <= if_done_n;
         ls_done_q     <= ls_done_n;
         if_data_q     <= if_data_n;
         ls_rdata_q    <= ls_rdata_n;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_dout = dout_q;
   assign mem_wr   = wr_q && rdy && !io_stall;
   assign if_done  = if_done_q;
   assign ls_done  = ls_done_q;
   assign if_data  = if_data_q;
   assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1, rdy = 1'b1, clr = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req = 1'b0, ls_wr = 1'b0;
   logic [1:0]  ls_size = 2'd0;
   logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full = 1'b0;
   logic        ram_init = 1'b1;
   logic [7:0]  ram [0:4095];

   int total = 0;
   int bad   = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after its address.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'(i) ^ 8'h5A;
         ram[12'h100] <= 8'h13;
         ram[12'h101] <= 8'h05;
         ram[12'h102] <= 8'h00;
         ram[12'h103] <= 8'h00;
      end else if (mem_wr) begin
         ram[mem_a[11:0]] <= mem_dout;
      end
      mem_din <= ram[mem_a[11:0]];
   end

   typedef struct {
      logic        is_if;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
      int          exp_nwr;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic is_if, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int clr_cyc, input int io_n,
                          output int lat, output logic [31:0] data, output int nwr);
      logic [31:0] sh;
      lat = -1; data = 32'd0; nwr = 0;
      if (is_if) begin
         if_addr = addr; if_req = 1'b1;
      end else begin
         ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
      end
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         step;
         clr = (c == clr_cyc);
         io_buffer_full = (c <= io_n);
         #2;
         if (mem_wr) begin
            sh = wdata >> (8 * nwr);
            chk("wr_addr", mem_a, addr + 32'(nwr));
            chk("wr_byte", {24'd0, mem_dout}, {24'd0, sh[7:0]});
            nwr++;
         end
         if (is_if ? if_done : ls_done) begin
            lat  = c;
            data = is_if ? if_data : ls_rdata;
         end
      end
      if_req = 1'b0; ls_req = 1'b0; clr = 1'b0; io_buffer_full = 1'b0;
      step;
   endtask

   int          lat, nwr, n_ev, pulses;
   logic [31:0] data;
   logic        ev [4];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0000_0513, 6, 0};
      vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_ABCD, 32'h0,         3, 2};
      vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0201, 32'h0,         32'h0000_00AB, 3, 0};
      vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0200, 32'h0,         32'h0000_ABCD, 4, 0};
      vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,         5, 4};
      vecs[5]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 6, 0};
      vecs[6]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 6, 0};
      vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0302, 32'h0,         32'h0000_00AD, 3, 0};
      vecs[8]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 6, 0};
      vecs[9]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0010, 32'h0,         32'h4948_4B4A, 6, 0};
      vecs[10] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,         5, 4};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h5958_1122, 6, 0};
      vecs[12] = '{1'b0, 1'b1, 2'd0, 32'h0000_0210, 32'hFFFF_FF5C, 32'h0,         2, 1};
      vecs[13] = '{1'b0, 1'b0, 2'd1, 32'h0000_0210, 32'h0,         32'h0000_4B5C, 4, 0};

      step; step;
      ram_init = 1'b0;
      #2;
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      step;
      rst = 1'b0;
      step;

      for (int v = 0; v < 14; v++) begin
         run_txn(vecs[v].is_if, vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata,
                 0, 0, lat, data, nwr);
         #2;
         chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
         chk($sformatf("v%0d_nwr", v), 32'(nwr), 32'(vecs[v].exp_nwr));
         if (!vecs[v].wr) chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
         chk($sformatf("v%0d_single_pulse", v), {30'd0, if_done, ls_done}, 32'd0);
      end

      // Fetch while clr is held in IDLE must not be granted.
      clr = 1'b1; if_addr = 32'h100; if_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step; #2;
         chk("clr_idle_no_grant", mem_a, 32'd0);
      end
      clr = 1'b0; if_req = 1'b0;
      step; step;

      // Flush in cycle 3 of a fetch.
      if_addr = 32'h100; if_req = 1'b1;
      step; step; step;
      clr = 1'b1; if_req = 1'b0;
      step;
      clr = 1'b0;
      #2;
      chk("flush_mem_a_idle", mem_a, 32'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (if_done) pulses++;
         step; #2;
      end
      chk("flush_no_if_done", 32'(pulses), 32'd0);

      // Flush during a 4-byte store: ignored.
      run_txn(1'b0, 1'b1, 2'd2, 32'h400, 32'h0A0B_0C0D, 2, 0, lat, data, nwr);
      chk("clr_store_lat", 32'(lat), 32'd5);
      chk("clr_store_nwr", 32'(nwr), 32'd4);
      run_txn(1'b0, 1'b0, 2'd2, 32'h400, 32'h0, 0, 0, lat, data, nwr);
      chk("clr_store_readback", data, 32'h0A0B_0C0D);

      // IO-region store with the UART buffer full for 3 cycles.
`ifdef MEM_IO_STALL_EN
      run_txn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h99, 0, 3, lat, data, nwr);
      chk("io_stall_lat", 32'(lat), 32'd5);
`else
      run_txn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h99, 0, 3, lat, data, nwr);
      chk("io_ignored_lat", 32'(lat), 32'd2);
`endif
      chk("io_nwr", 32'(nwr), 32'd1);

      // Reset during IF_RD.
      if_addr = 32'h100; if_req = 1'b1;
      step; step;
      rst = 1'b1; if_req = 1'b0;
      step;
      rst = 1'b0;
      #2;
      chk("midrst_mem_a", mem_a, 32'd0);
      chk("midrst_wr_dout", {23'd0, mem_wr, mem_dout}, 32'd0);
      chk("midrst_if_data", if_data, 32'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (if_done) pulses++;
         step; #2;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);

      // Contention straight after reset: LS first, then alternating.
      rst = 1'b1; step; step; rst = 1'b0;
      ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h201; if_addr = 32'h100;
      ls_req = 1'b1; if_req = 1'b1;
      n_ev = 0;
      for (int c = 0; c < 60 && n_ev < 4; c++) begin
         step; #2;
         if (ls_done) begin
            ev[n_ev] = 1'b1; n_ev++;
            chk("cont_ls_rdata", ls_rdata, 32'h0000_00AB);
         end else if (if_done) begin
            ev[n_ev] = 1'b0; n_ev++;
            chk("cont_if_data", if_data, 32'h0000_0513);
         end
      end
      ls_req = 1'b0; if_req = 1'b0;
      step; step;
      chk("cont_events", 32'(n_ev), 32'd4);
      for (int e = 0; e < 4 && e < n_ev; e++)
         chk($sformatf("cont_grant%0d_is_ls", e), {31'd0, ev[e]}, {31'd0, (e % 2 == 0)});

      // rdy low for 2 cycles in the middle of a 4-byte store.
      ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h4433_2211; ls_req = 1'b1;
      step; #2;
      chk("rdy_c1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0500, 7'd0, 1'b1, 8'h11});
      step; rdy = 1'b0; #2;
      chk("rdy_c2_wr", {31'd0, mem_wr}, 32'd0);
      step; #2;
      chk("rdy_c3", {mem_a[15:0], 7'd0, mem_wr, 8'd0}, {16'h0501, 7'd0, 1'b0, 8'd0});
      step; rdy = 1'b1; #2;
      chk("rdy_c4", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0501, 7'd0, 1'b1, 8'h22});
      step; #2;
      chk("rdy_c5", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0502, 7'd0, 1'b1, 8'h33});
      step; #2;
      chk("rdy_c6", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0503, 7'd0, 1'b1, 8'h44});
      step; #2;
      chk("rdy_c7_done", {31'd0, ls_done}, 32'd1);
      ls_req = 1'b0;
      step;
      run_txn(1'b0, 1'b0, 2'd2, 32'h500, 32'h0, 0, 0, lat, data, nwr);
      chk("rdy_readback", data, 32'h4433_2211);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
